// File: rtl/seg14_msg_source.sv
// seg14_msg_source: ASCII message buffer with 14-segment font lookup and scrolling glyph read port
module seg14_msg_source #(
    parameter int MSG_DEPTH  = 32,
    parameter int DIGITS     = 12,
    parameter int SCROLL_DIV = 12000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        len_wr,
    input  logic [5:0]  len_data,
    input  logic        scroll_en,
    input  logic        rd_en,
    input  logic [3:0]  rd_idx,
    output logic        rd_valid,
    output logic [13:0] rd_seg,
    output logic [4:0]  offset,
    output logic        wrap_pulse
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int PW = $clog2(SCROLL_DIV);

    logic [7:0]    msg [MSG_DEPTH];
    logic [5:0]    len;
    logic [PW-1:0] pre;
    logic [5:0]    sum;
    logic [5:0]    addr;
    logic          blank;
    logic          scroll_act;
    logic          tc;
    logic          last;

    // Bit 13 = a, then b c d e f g1 g2, upper diagonals/center (h j k), lower right/center/left.
    function automatic logic [13:0] glyph(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        case (u)
            "A": glyph = 14'h3BC0;
            "B": glyph = 14'h3C52;
            "C": glyph = 14'h2700;
            "D": glyph = 14'h3C12;
            "E": glyph = 14'h2780;
            "F": glyph = 14'h2380;
            "G": glyph = 14'h2F40;
            "H": glyph = 14'h1BC0;
            "I": glyph = 14'h2412;
            "J": glyph = 14'h1E00;
            "K": glyph = 14'h038C;
            "L": glyph = 14'h0700;
            "M": glyph = 14'h1B28;
            "N": glyph = 14'h1B24;
            "O": glyph = 14'h3F00;
            "P": glyph = 14'h33C0;
            "Q": glyph = 14'h3F04;
            "R": glyph = 14'h33C4;
            "S": glyph = 14'h2DC0;
            "T": glyph = 14'h2012;
            "U": glyph = 14'h1F00;
            "V": glyph = 14'h0309;
            "W": glyph = 14'h1B05;
            "X": glyph = 14'h002D;
            "Y": glyph = 14'h002A;
            "Z": glyph = 14'h2409;
            "0": glyph = 14'h3F09;
            "1": glyph = 14'h1808;
            "2": glyph = 14'h36C0;
            "3": glyph = 14'h3C40;
            "4": glyph = 14'h19C0;
            "5": glyph = 14'h2DC0;
            "6": glyph = 14'h2FC0;
            "7": glyph = 14'h3800;
            "8": glyph = 14'h3FC0;
            "9": glyph = 14'h3DC0;
            default: glyph = 14'h0000;
        endcase
    endfunction

    // Map digit index to buffer entry; offset < len and rd_idx < len keep the wrap to one subtract.
    always_comb begin
        sum        = 6'(offset) + 6'(rd_idx);
        addr       = (sum >= len) ? sum - len : sum;
        blank      = (len == 6'd0) || (32'(rd_idx) >= DIGITS) || (32'(len) <= DIGITS && 6'(rd_idx) >= len);
        scroll_act = (32'(len) > DIGITS) && scroll_en;
        tc         = pre == PW'(SCROLL_DIV - 1);
        last       = {1'b0, offset} == len - 6'd1;
    end

    // Message buffer, filled with spaces on reset; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) msg[i] <= 8'h20;
        end else if (wr_en && 32'(wr_addr) < MSG_DEPTH) begin
            msg[AW'(wr_addr)] <= wr_data;
        end
    end

    // Length load and scroll stepping; a length load overrides a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            pre        <= '0;
            offset     <= '0;
            wrap_pulse <= 1'b0;
        end else if (len_wr) begin
            len        <= (len_data > 6'(MSG_DEPTH)) ? 6'(MSG_DEPTH) : len_data;
            pre        <= '0;
            offset     <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            pre        <= scroll_act ? (tc ? '0 : pre + 1'b1) : pre;
            offset     <= (scroll_act && tc) ? (last ? 5'd0 : offset + 5'd1) : offset;
            wrap_pulse <= scroll_act && tc && last;
        end
    end

    // Registered glyph fetch; rd_seg holds its value between fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_seg   <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_seg <= blank ? 14'h0000 : glyph(msg[AW'(addr)]);
        end
    end
endmodule

// File: tb/tb_seg14_msg_source.sv
// tb_seg14_msg_source: directed self-checking bench for seg14_msg_source
module tb_seg14_msg_source;
    localparam logic [13:0] G_S = 14'h2DC0;
    localparam logic [13:0] G_O = 14'h3F00;
    localparam logic [13:0] G_Y = 14'h002A;
    localparam logic [13:0] G_E = 14'h2780;
    localparam logic [13:0] G_X = 14'h002D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        len_wr;
    logic [5:0]  len_data;
    logic        scroll_en;
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic        rd_valid;
    logic [13:0] rd_seg;
    logic [4:0]  offset;
    logic        wrap_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8*12-1:0] text = "SOY SERGIOXX";

    seg14_msg_source #(.MSG_DEPTH(32), .DIGITS(12), .SCROLL_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_wr(len_wr), .len_data(len_data), .scroll_en(scroll_en), .rd_en(rd_en),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_seg(rd_seg), .offset(offset),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_len(input logic [5:0] l);
        len_wr = 1'b1; len_data = l;
        tick();
        len_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [13:0] exp, input string tag);
        rd_en = 1'b1; rd_idx = idx;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_seg), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_wr = 1'b0;
        len_data = '0; scroll_en = 1'b0; rd_en = 1'b0; rd_idx = '0;
        #1;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_seg", 32'(rd_seg), 32'd0);
        check("rst_offset", 32'(offset), 32'd0);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        #11;
        rst_n = 1'b1; rd_en = 1'b1; rd_idx = 4'd3;
        tick();
        rd_en = 1'b0;
        check("first_rd_valid", 32'(rd_valid), 32'd1);
        check("first_rd_seg", 32'(rd_seg), 32'd0);

        scroll_en = 1'b1;
        for (int i = 0; i < 12; i++) wr(5'(i), text[8*(11-i) +: 8]);
        set_len(6'd12);
        rd(4'd0, G_S, "static_0");
        rd(4'd1, G_O, "static_1");
        rd(4'd2, G_Y, "static_2");
        rd(4'd3, 14'h0000, "static_3");
        rd(4'd11, G_X, "static_11");
        tick();
        check("idle_valid", 32'(rd_valid), 32'd0);
        check("idle_hold", 32'(rd_seg), 32'(G_X));
        repeat (20) tick();
        check("static_offset", 32'(offset), 32'd0);

        set_len(6'd0);
        rd(4'd0, 14'h0000, "len0_0");
        rd(4'd11, 14'h0000, "len0_11");

        wr(5'd12, "e");
        wr(5'd13, "I");
        scroll_en = 1'b0;
        set_len(6'd14);
        rd(4'd12, 14'h0000, "idx_ge_digits");
        rd(4'd0, G_S, "l14_0");

        scroll_en = 1'b1;
        set_len(6'd14);
        repeat (3) tick();
        check("scroll_e3", 32'(offset), 32'd0);
        tick();
        check("scroll_e4", 32'(offset), 32'd1);
        rd(4'd11, G_E, "scroll_idx11");
        repeat (47) tick();
        check("scroll_off13", 32'(offset), 32'd13);
        rd(4'd1, G_S, "scroll_wrapidx1");
        repeat (2) tick();
        check("prewrap_pulse", 32'(wrap_pulse), 32'd0);
        tick();
        check("wrap_offset", 32'(offset), 32'd0);
        check("wrap_pulse", 32'(wrap_pulse), 32'd1);
        tick();
        check("wrap_pulse_end", 32'(wrap_pulse), 32'd0);

        set_len(6'd14);
        repeat (55) tick();
        check("tc_off13", 32'(offset), 32'd13);
        set_len(6'd14);
        check("tc_len_offset", 32'(offset), 32'd0);
        check("tc_len_wrap", 32'(wrap_pulse), 32'd0);
        tick();
        check("tc_len_wrap2", 32'(wrap_pulse), 32'd0);

        set_len(6'd14);
        repeat (6) tick();
        check("frz_pre", 32'(offset), 32'd1);
        scroll_en = 1'b0;
        repeat (100) tick();
        check("frz_hold", 32'(offset), 32'd1);
        scroll_en = 1'b1;
        tick();
        check("frz_resume1", 32'(offset), 32'd1);
        tick();
        check("frz_resume2", 32'(offset), 32'd2);

        set_len(6'd5);
        rd(4'd4, G_S, "l5_4");
        for (int i = 5; i < 12; i++) rd(4'(i), 14'h0000, "l5_blank");
        check("l5_offset", 32'(offset), 32'd0);

        set_len(6'd40);
        repeat (127) tick();
        check("l40_off31", 32'(offset), 32'd31);
        check("l40_nowrap", 32'(wrap_pulse), 32'd0);
        tick();
        check("l40_wrap_off", 32'(offset), 32'd0);
        check("l40_wrap", 32'(wrap_pulse), 32'd1);

        scroll_en = 1'b0;
        set_len(6'd12);
        rd_en = 1'b1; rd_idx = 4'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = "O";
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("coll_old", 32'(rd_seg), 32'(G_S));
        rd(4'd0, G_O, "coll_new");

        wr(5'd1, "#");
        wr(5'd2, 8'h7F);
        wr(5'd3, "y");
        rd(4'd1, 14'h0000, "font_hash");
        rd(4'd2, 14'h0000, "font_7f");
        rd(4'd3, G_Y, "font_lower_y");

        scroll_en = 1'b1;
        set_len(6'd14);
        repeat (10) tick();
        rd_en = 1'b1; rd_idx = 4'd3;
        tick();
        check("mid_seg", 32'(rd_seg), 32'(G_E));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(rd_valid), 32'd0);
        check("async_seg", 32'(rd_seg), 32'd0);
        check("async_offset", 32'(offset), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; rd_idx = 4'd0;
        tick();
        rd_en = 1'b0;
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        check("post_rst_seg", 32'(rd_seg), 32'd0);
        set_len(6'd12);
        rd(4'd0, 14'h0000, "post_rst_space");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
